// File: rtl/sha_types_pkg.sv
// Hash types shared with sha_super_pipelined_core and the flattening helper used by the scanner.
// Build macro HASH_SCAN_BYTE_REVERSE_EN selects little-endian byte order when a..h is flattened.
package sha_types_pkg;

  localparam int HASH_W = 256;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } HashState;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } scan_state_t;

  function automatic logic [HASH_W-1:0] hashstate_to_bits(input HashState hs);
    logic [HASH_W-1:0] w_flat;
    logic [HASH_W-1:0] w_bits;
    w_flat = hs;
`ifdef HASH_SCAN_BYTE_REVERSE_EN
    // Byte 0 of a becomes the least significant byte: Bitcoin compares the digest little-endian.
    for (int i = 0; i < HASH_W / 8; i++) begin
      w_bits[8*i +: 8] = w_flat[HASH_W-1-8*i -: 8];
    end
`else
    w_bits = w_flat;
`endif
    return w_bits;
  endfunction

endpackage

// File: rtl/hash_result_scanner_if.sv
// Core-output and host-result signals of the scanner; master drives the core side and found_ready.
// The scanner never backpressures the core; found_* is a valid/ready pair to the host.
interface hash_result_scanner_if #(
  parameter int NONCE_W = 32
);
  logic                      output_valid;
  logic                      newblock_o;
  sha_types_pkg::HashState   doublehash;
  logic [255:0]              target;
  logic                      found_valid;
  logic [NONCE_W-1:0]        found_nonce;
  logic                      found_ready;
  logic                      overflow;
  logic [NONCE_W-1:0]        scanned;

  modport master (
    output output_valid, newblock_o, doublehash, target, found_ready,
    input  found_valid, found_nonce, overflow, scanned
  );

  modport slave (
    input  output_valid, newblock_o, doublehash, target, found_ready,
    output found_valid, found_nonce, overflow, scanned
  );
endinterface

// File: rtl/target_compare_256.sv
// Pipelined unsigned hash <= target: four 64-bit partial compares registered, then a combine.
// Latency LAT (1 or 2) cycles; no backpressure, accepts a new compare every cycle.
module target_compare_256 #(
  parameter int NONCE_W = 32,
  parameter int LAT     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_vld,
  input  logic [255:0]       i_hash,
  input  logic [255:0]       i_target,
  input  logic [NONCE_W-1:0] i_nonce,
  output logic               o_vld,
  output logic               o_win,
  output logic [NONCE_W-1:0] o_nonce
);

  logic [3:0]         w_lt;
  logic [3:0]         w_eq;
  logic               w_le;
  logic               r_s1_vld;
  logic [3:0]         r_s1_lt;
  logic [3:0]         r_s1_eq;
  logic [NONCE_W-1:0] r_s1_nonce;

  for (genvar k = 0; k < 4; k++) begin : g_part
    assign w_lt[k] = i_hash[64*k +: 64] <  i_target[64*k +: 64];
    assign w_eq[k] = i_hash[64*k +: 64] == i_target[64*k +: 64];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_lt    <= '0;
      r_s1_eq    <= '0;
      r_s1_nonce <= '0;
    end else begin
      r_s1_vld   <= i_vld;
      r_s1_lt    <= w_lt;
      r_s1_eq    <= w_eq;
      r_s1_nonce <= i_nonce;
    end
  end

  // Most significant chunk decides unless equal, then fall through to the next one down.
  assign w_le = r_s1_lt[3] | (r_s1_eq[3] & (r_s1_lt[2] | (r_s1_eq[2] &
                (r_s1_lt[1] | (r_s1_eq[1] & (r_s1_lt[0] | r_s1_eq[0]))))));

  if (LAT == 1) begin : g_lat1
    assign o_vld   = r_s1_vld;
    assign o_win   = w_le;
    assign o_nonce = r_s1_nonce;
  end else begin : g_lat2
    logic               r_s2_vld;
    logic               r_s2_win;
    logic [NONCE_W-1:0] r_s2_nonce;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_s2_vld   <= 1'b0;
        r_s2_win   <= 1'b0;
        r_s2_nonce <= '0;
      end else begin
        r_s2_vld   <= r_s1_vld;
        r_s2_win   <= w_le;
        r_s2_nonce <= r_s1_nonce;
      end
    end

    assign o_vld   = r_s2_vld;
    assign o_win   = r_s2_win;
    assign o_nonce = r_s2_nonce;
  end

endmodule

// File: rtl/hash_result_scanner.sv
// Numbers each valid double hash in its block, tests it against the target, holds winners for the host.
// Win reaches found_valid LAT+1 cycles after the hash; never stalls the core, drops wins while held (overflow).
module hash_result_scanner
  import sha_types_pkg::*;
#(
  parameter int NONCE_W = 32,
  parameter int LAT     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  hash_result_scanner_if.slave bus
);

  scan_state_t         r_state;
  logic [NONCE_W-1:0]  r_cnt;
  logic [HASH_W-1:0]   r_target;
  logic                r_found_valid;
  logic [NONCE_W-1:0]  r_found_nonce;
  logic                r_overflow;

  logic                w_start;
  logic                w_accept;
  logic [HASH_W-1:0]   w_hash;
  logic [HASH_W-1:0]   w_target;
  logic [NONCE_W-1:0]  w_nonce;
  logic                w_pipe_vld;
  logic                w_pipe_win;
  logic [NONCE_W-1:0]  w_win_nonce;
  logic                w_win;

  assign w_start  = bus.output_valid & bus.newblock_o;
  // Before the first block start there is no target or nonce base, so those hashes are ignored.
  assign w_accept = bus.output_valid & ((r_state != ST_IDLE) | bus.newblock_o);
  assign w_hash   = hashstate_to_bits(bus.doublehash);
  assign w_target = w_start ? bus.target : r_target;
  assign w_nonce  = w_start ? '0 : r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_target <= '1;
    end else begin
      if (w_accept) begin
        r_cnt <= w_start ? NONCE_W'(1) : r_cnt + NONCE_W'(1);
      end
      if (w_start) begin
        r_target <= bus.target;
      end
    end
  end

  target_compare_256 #(
    .NONCE_W (NONCE_W),
    .LAT     (LAT)
  ) u_cmp (
    .clk      (clk),
    .rst      (rst),
    .i_vld    (w_accept),
    .i_hash   (w_hash),
    .i_target (w_target),
    .i_nonce  (w_nonce),
    .o_vld    (w_pipe_vld),
    .o_win    (w_pipe_win),
    .o_nonce  (w_win_nonce)
  );

  assign w_win = w_pipe_vld & w_pipe_win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_found_valid <= 1'b0;
      r_found_nonce <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_start) begin
        r_overflow <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_win) begin
            r_found_nonce <= w_win_nonce;
            r_found_valid <= 1'b1;
            r_state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.found_ready) begin
            if (w_win) begin
              r_found_nonce <= w_win_nonce;
            end else begin
              r_found_valid <= 1'b0;
              r_state       <= ST_SCAN;
            end
          end else if (w_win) begin
            // A drop outranks a same-cycle block start so the loss is never hidden.
            r_overflow <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.found_valid = r_found_valid;
  assign bus.found_nonce = r_found_nonce;
  assign bus.overflow    = r_overflow;
  assign bus.scanned     = r_cnt;

endmodule

// File: doc/hash_result_scanner.md
Name: hash_result_scanner

Overview:
- Consumes the double-SHA output stream of sha_super_pipelined_core: doublehash, output_valid and newblock_o.
- Tracks the nonce index of every valid hash within the current block and compares each hash against a 256-bit target.
- Captures winning nonces and offers them to the host controller over a valid/ready handshake.
- Sits between the hashing core and the work/host interface; it is the receive end of the core's output protocol.

Parameters:
- NONCE_W, 32, width of the nonce index counter and reported nonce.
- LAT, 2, fixed compare pipeline depth in cycles (valid values 1 or 2).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- output_valid  in  1  core output qualifier; one hash per asserted cycle
- newblock_o  in  1  marks the first valid hash of a new block (nonce index 0); meaningful only with output_valid
- doublehash  in  HashState  a..h words of the double hash
- target  in  256  difficulty target, sampled when newblock_o && output_valid
- found_valid  out  1  winning nonce available
- found_nonce  out  NONCE_W  nonce index of the winning hash
- found_ready  in  1  host accepts the held result
- overflow  out  1  sticky: a win was dropped while a result was held
- scanned  out  NONCE_W  count of hashes scanned in the current block

Behaviour:
- Reset (rst=0, asynchronous): found_valid=0, found_nonce=0, overflow=0, scanned=0, nonce counter=0, target register=all-ones, FSM=IDLE, compare pipeline valids=0.
- Hash value H = {a,b,c,d,e,f,g,h}, with a in the MSBs.
- A hash wins iff H <= target_reg, using an unsigned 256-bit compare.
- Nonce counter:
  - On output_valid && newblock_o, the hash gets nonce 0, the counter becomes 1 and target_reg loads target. The win test for this same hash uses the newly sampled target.
  - On output_valid && !newblock_o, the hash gets the current counter value and the counter increments.
  - The counter wraps from 2^NONCE_W-1 to 0 with no flag.
  - Cycles without output_valid leave the counter unchanged.
- scanned mirrors the counter, registered.
- Compare pipeline: the win decision plus its nonce emerge LAT cycles after the input cycle. There is no backpressure to the core; the scanner accepts every valid hash.
- FSM, IDLE -> SCAN -> HOLD:
  - IDLE: waits for the first output_valid && newblock_o, then goes to SCAN. Hashes arriving before any newblock_o are ignored and not counted.
  - SCAN: on a pipeline win, loads found_nonce, sets found_valid=1 and goes to HOLD.
  - HOLD: found_valid stays 1 and found_nonce stays stable until found_valid && found_ready, then returns to SCAN. A win in the same cycle as acceptance loads the new nonce and stays in HOLD, so there is no bubble. A win in HOLD without acceptance is dropped and overflow is set.
- overflow clears only on reset or on newblock_o && output_valid.
- A newblock_o in SCAN or HOLD:
  - restarts the counter;
  - the held result is kept until accepted;
  - wins still in the pipeline from the old block still report their old nonces.
- Asserting reset mid-block discards all in-flight wins immediately.

Optional Feature:
- Macro: HASH_SCAN_BYTE_REVERSE_EN.
- Defined: H is the full 32-byte reversal of {a..h}, giving Bitcoin little-endian ordering, before the compare.
- Not defined: H is {a..h} unmodified.
- Port list and latency are identical in both builds.

Decomposition:
- Package sha_types_pkg holds:
  - the HashState struct (a..h, 32 bits each), shared with sha_super_pipelined_core;
  - the HASH_W=256 constant;
  - the function hashstate_to_bits (flattening, with optional reversal).
- Sub-module target_compare_256: registered, pipelined unsigned <= compare, split as 4x64-bit partial compares in stage 1 and a combine in stage 2 (when LAT=2).

Test Plan:
- Win and hand-off: target=all-ones, newblock_o with the first valid hash, found_ready=0 -> found_valid=1 with found_nonce=0 at LAT+1 cycles; overflow=1 after the second valid hash's win is dropped.
- Single match in a stream: target=256'h0000_0000_FFFF..., 10 valid hashes with only the 7th's a-word equal to 0 -> found_nonce=6 and a single found_valid pulse after found_ready=1.
- Gaps in output_valid: output_valid toggling 1,0,0,1 over 8 cycles -> scanned=4, and a win on the 4th valid hash reports nonce 3.
- Back-to-back wins with found_ready=1 in every cycle: consecutive nonces 0..4 are presented on consecutive cycles and overflow stays 0.
- Mid-block newblock_o: newblock_o at nonce 50 with overflow=1 -> overflow=0, scanned=1, and the next valid hash gets nonce 1.
- Byte-reverse build: doublehash h=32'h00000000, other words nonzero, target=256'h00000000FFFF... -> win only when HASH_SCAN_BYTE_REVERSE_EN is defined. Reset asserted mid-HOLD -> found_valid=0 asynchronously.
